// File: rtl/usb_pkg.sv
// usb_pkg: shared USB token-receiver constants, error encoding, FSM state type
// and token field layout.
package usb_pkg;

  localparam int unsigned PID_W   = 4;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ENDP_W  = 4;
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned CRC_W   = 5;

  localparam logic [PID_W-1:0] PID_OUT   = 4'h1;
  localparam logic [PID_W-1:0] PID_SOF   = 4'h5;
  localparam logic [PID_W-1:0] PID_IN    = 4'h9;
  localparam logic [PID_W-1:0] PID_SETUP = 4'hD;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_PID  = 3'd1,
    ERR_CRC  = 3'd2,
    ERR_LEN  = 3'd3,
    ERR_RX   = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOK1,
    ST_TOK2,
    ST_DONE,
    ST_DROP
  } state_e;

  // 11-bit token field as it arrives on the wire: {b3[2:0], b2}
  typedef struct packed {
    logic [ENDP_W-1:0] endp;
    logic [ADDR_W-1:0] addr;
  } token_fields_t;

  function automatic logic pid_is_token(input logic [PID_W-1:0] pid, input logic sof_en);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) ||
           (sof_en && (pid == PID_SOF));
  endfunction

endpackage

// File: rtl/usb_token_crc5.sv
// usb_token_crc5: CRC5 (x^5+x^2+1) advanced over an 11-bit token field,
// bits taken LSB first as they appear on the wire.
module usb_token_crc5
  import usb_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic [10:0]      data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ data_i[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_token_rx.sv
// usb_token_rx: decodes OUT/IN/SETUP token packets from a UTMI-style byte stream,
// checking PID, CRC5 and length. SOF decode is enabled by defining USB_TOKEN_SOF_EN.
module usb_token_rx
  import usb_pkg::*;
#(
  parameter bit ADDR_FILTER = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  input  logic               rx_active_i,
  input  logic               rx_error_i,
  input  logic [ADDR_W-1:0]  dev_addr_i,
  output logic               token_valid_o,
  output logic [PID_W-1:0]   token_pid_o,
  output logic [ADDR_W-1:0]  token_addr_o,
  output logic [ENDP_W-1:0]  token_endp_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               err_o,
  output logic [2:0]         err_code_o
);

`ifdef USB_TOKEN_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  state_e           state, state_next;
  logic             active_q;
  logic             err_seen, err_seen_next;
  logic [PID_W-1:0] pid_q, pid_next;
  logic [7:0]       b2_q, b2_next, b3_q, b3_next;

  logic [10:0]      field;
  token_fields_t    tf;
  logic [CRC_W-1:0] crc_raw, crc_chk;
  logic             crc_ok, addr_ok;
  logic             tok_strobe, err_strobe;
  err_code_e        err_code;

  assign field = {b3_q[2:0], b2_q};
  assign tf    = token_fields_t'(field);

  usb_token_crc5 u_crc (
    .crc_i  (5'h1F),
    .data_i (field),
    .crc_o  (crc_raw)
  );

  // Received CRC field carries the complemented remainder MSB first
  assign crc_chk = ~crc_raw;
  assign crc_ok  = (b3_q[7:3] == {crc_chk[0], crc_chk[1], crc_chk[2], crc_chk[3], crc_chk[4]});
  assign addr_ok = !ADDR_FILTER || (pid_q == PID_SOF) || (tf.addr == dev_addr_i);

  always_comb begin
    state_next    = state;
    err_seen_next = err_seen;
    pid_next      = pid_q;
    b2_next       = b2_q;
    b3_next       = b3_q;
    tok_strobe    = 1'b0;
    err_strobe    = 1'b0;
    err_code      = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        err_seen_next = 1'b0;
        // A packet already running when we got here (e.g. after reset) is not ours
        if (rx_active_i) state_next = active_q ? ST_DROP : ST_PID;
      end
      ST_PID: begin
        if (rx_error_i) begin
          err_strobe = 1'b1; err_code = ERR_RX;  state_next = ST_DROP;
        end else if (!rx_active_i) begin
          err_strobe = 1'b1; err_code = ERR_LEN; state_next = ST_IDLE;
        end else if (rx_valid_i) begin
          if (rx_data_i[7:4] != ~rx_data_i[3:0]) begin
            err_strobe = 1'b1; err_code = ERR_PID; state_next = ST_DROP;
          end else if (!pid_is_token(rx_data_i[3:0], SOF_EN)) begin
            state_next = ST_DROP;
          end else begin
            pid_next   = rx_data_i[3:0];
            state_next = ST_TOK1;
          end
        end
      end
      ST_TOK1: begin
        if (rx_error_i) begin
          err_strobe = 1'b1; err_code = ERR_RX;  state_next = ST_DROP;
        end else if (!rx_active_i) begin
          err_strobe = 1'b1; err_code = ERR_LEN; state_next = ST_IDLE;
        end else if (rx_valid_i) begin
          b2_next    = rx_data_i;
          state_next = ST_TOK2;
        end
      end
      ST_TOK2: begin
        if (rx_error_i) begin
          err_strobe = 1'b1; err_code = ERR_RX;  state_next = ST_DROP;
        end else if (!rx_active_i) begin
          err_strobe = 1'b1; err_code = ERR_LEN; state_next = ST_IDLE;
        end else if (rx_valid_i) begin
          b3_next    = rx_data_i;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rx_error_i) begin
          err_strobe = 1'b1; err_code = ERR_RX;  state_next = ST_DROP;
        end else if (rx_valid_i) begin
          err_strobe = 1'b1; err_code = ERR_LEN; state_next = ST_DROP;
        end else if (!rx_active_i) begin
          state_next = ST_IDLE;
          if (!crc_ok) begin
            err_strobe = 1'b1; err_code = ERR_CRC;
          end else if (addr_ok) begin
            tok_strobe = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (rx_error_i && !err_seen) begin
          err_strobe = 1'b1; err_code = ERR_RX;
        end
        if (!rx_active_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (err_strobe) err_seen_next = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      active_q <= 1'b1;
      err_seen <= 1'b0;
    end else begin
      state    <= state_next;
      active_q <= rx_active_i;
      err_seen <= err_seen_next;
    end
  end

  // Captured bytes and registered outputs; token fields hold between strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pid_q         <= '0;
      b2_q          <= '0;
      b3_q          <= '0;
      token_valid_o <= 1'b0;
      token_pid_o   <= '0;
      token_addr_o  <= '0;
      token_endp_o  <= '0;
      err_o         <= 1'b0;
      err_code_o    <= '0;
    end else begin
      pid_q         <= pid_next;
      b2_q          <= b2_next;
      b3_q          <= b3_next;
      token_valid_o <= tok_strobe;
      err_o         <= err_strobe;
      if (err_strobe) err_code_o <= 3'(err_code);
      if (tok_strobe) begin
        token_pid_o  <= pid_q;
        token_addr_o <= tf.addr;
        token_endp_o <= tf.endp;
      end
    end
  end

`ifdef USB_TOKEN_SOF_EN
  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= '0;
    end else if (tok_strobe && (pid_q == PID_SOF)) begin
      frame_q <= field;
    end
  end

  assign frame_o = frame_q;
`else
  assign frame_o = '0;
`endif

endmodule

// File: tb/tb_usb_token_rx.sv
// tb_usb_token_rx: table vectors, hand-written corner sequences and random packets
// against a packet-level reference model, on an unfiltered and a filtered instance.
module tb_usb_token_rx;

`ifdef USB_TOKEN_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_active, rx_error;
  logic [6:0]  dev_addr;

  logic        tv    [2];
  logic [3:0]  pid   [2];
  logic [6:0]  addr  [2];
  logic [3:0]  endp  [2];
  logic [10:0] frame [2];
  logic        ev    [2];
  logic [2:0]  code  [2];

  usb_token_rx #(.ADDR_FILTER(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_active_i(rx_active), .rx_error_i(rx_error), .dev_addr_i(dev_addr),
    .token_valid_o(tv[0]), .token_pid_o(pid[0]), .token_addr_o(addr[0]),
    .token_endp_o(endp[0]), .frame_o(frame[0]), .err_o(ev[0]), .err_code_o(code[0])
  );

  usb_token_rx #(.ADDR_FILTER(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_active_i(rx_active), .rx_error_i(rx_error), .dev_addr_i(dev_addr),
    .token_valid_o(tv[1]), .token_pid_o(pid[1]), .token_addr_o(addr[1]),
    .token_endp_o(endp[1]), .frame_o(frame[1]), .err_o(ev[1]), .err_code_o(code[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int tok_n [2];
  int err_n [2];
  int tok_cyc [2];
  logic [2:0]  last_code [2];
  logic [3:0]  m_pid   [2];
  logic [6:0]  m_addr  [2];
  logic [3:0]  m_endp  [2];
  logic [10:0] m_frame [2];

  typedef struct {
    logic [31:0] bytes;   // byte0 in [7:0]
    int          n;
    logic [6:0]  dev;
    logic [2:0]  ecode;
    bit          tok0;
    bit          tok1;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // One clock: drive inputs, clock, then observe registered outputs
  task automatic step(input bit act, input bit vld, input logic [7:0] d, input bit er);
    rx_active = act; rx_valid = vld; rx_data = d; rx_error = er;
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (tv[k]) begin tok_n[k]++; tok_cyc[k] = cyc; end
      if (ev[k]) begin err_n[k]++; last_code[k] = code[k]; end
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      tok_n[k] = 0; err_n[k] = 0; tok_cyc[k] = -1; last_code[k] = 3'd7;
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_pid[k] = '0; m_addr[k] = '0; m_endp[k] = '0; m_frame[k] = '0;
    end
  endtask

  // USB CRC5 residual over the 16 bits following the PID; a good token leaves 5'b01100
  function automatic logic [4:0] residual(input logic [7:0] b2, input logic [7:0] b3);
    logic [15:0] bits;
    logic [4:0]  r;
    logic        fb;
    bits = {b3, b2};
    r = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      fb = r[4] ^ bits[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] make_b3(input logic [10:0] f);
    logic [7:0] b3;
    for (int v = 0; v < 32; v++) begin
      b3 = {5'(v), f[10:8]};
      if (residual(f[7:0], b3) == 5'h0C) return b3;
    end
    return 8'h00;
  endfunction

  function automatic void model(input logic [7:0] pk [6], input int n, input bit filt,
                                input logic [6:0] dev, output bit tok, output logic [2:0] ecode);
    logic [3:0]  p;
    logic [10:0] f;
    tok = 1'b0; ecode = 3'd0;
    if (n == 0) begin ecode = 3'd3; return; end
    p = pk[0][3:0];
    if (pk[0][7:4] != ~p) begin ecode = 3'd1; return; end
    if (!(p == 4'h1 || p == 4'h9 || p == 4'hD || (SOF_EN && p == 4'h5))) return;
    if (n != 3) begin ecode = 3'd3; return; end
    if (residual(pk[1], pk[2]) != 5'h0C) begin ecode = 3'd2; return; end
    f = {pk[2][2:0], pk[1]};
    if (filt && p != 4'h5 && f[6:0] != dev) return;
    tok = 1'b1;
  endfunction

  task automatic send_pkt(input logic [7:0] pk [6], input int n);
    int g;
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
    clear_counts();
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) step(1, 0, 8'($urandom), 0);
      step(1, 1, pk[i], 0);
    end
    g = $urandom_range(0, 1);
    for (int j = 0; j < g; j++) step(1, 0, 8'($urandom), 0);
    fall_cyc = cyc + 1;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
  endtask

  task automatic verify(input string tag, input int k, input bit etok, input logic [2:0] ecode,
                        input logic [7:0] b0, input logic [7:0] b2, input logic [7:0] b3);
    check({tag, " token_count"}, k, tok_n[k], 32'(etok));
    check({tag, " err_count"}, k, err_n[k], (ecode != 3'd0) ? 1 : 0);
    if (ecode != 3'd0) check({tag, " err_code"}, k, 32'(last_code[k]), 32'(ecode));
    if (etok) begin
      check({tag, " latency"}, k, tok_cyc[k], fall_cyc);
      m_pid[k]  = b0[3:0];
      m_addr[k] = b2[6:0];
      m_endp[k] = {b3[2:0], b2[7]};
      if (SOF_EN && b0[3:0] == 4'h5) m_frame[k] = {b3[2:0], b2};
    end
    check({tag, " pid"},   k, 32'(pid[k]),   32'(m_pid[k]));
    check({tag, " addr"},  k, 32'(addr[k]),  32'(m_addr[k]));
    check({tag, " endp"},  k, 32'(endp[k]),  32'(m_endp[k]));
    check({tag, " frame"}, k, 32'(frame[k]), 32'(m_frame[k]));
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, " token_valid"}, k, 32'(tv[k]),    0);
      check({tag, " err"},         k, 32'(ev[k]),    0);
      check({tag, " err_code"},    k, 32'(code[k]),  0);
      check({tag, " pid"},         k, 32'(pid[k]),   0);
      check({tag, " addr"},        k, 32'(addr[k]),  0);
      check({tag, " endp"},        k, 32'(endp[k]),  0);
      check({tag, " frame"},       k, 32'(frame[k]), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pk [6];
    logic [3:0]  tokp [4];
    logic [3:0]  p;
    logic [10:0] f;
    int          n, kind;
    bit          etok;
    logic [2:0]  ecode;

    tokp[0] = 4'h1; tokp[1] = 4'h9; tokp[2] = 4'hD; tokp[3] = 4'h5;

    vt[0] = '{32'h0010_002D, 3, 7'd0, 3'd0, 1'b1, 1'b1};
    vt[1] = '{32'h0010_002D, 3, 7'd5, 3'd0, 1'b1, 1'b0};
    vt[2] = '{32'h0011_002D, 3, 7'd0, 3'd2, 1'b0, 1'b0};
    vt[3] = '{32'h0010_002C, 3, 7'd0, 3'd1, 1'b0, 1'b0};
    vt[4] = '{32'h0000_002D, 2, 7'd0, 3'd3, 1'b0, 1'b0};
    vt[5] = '{32'h5510_002D, 4, 7'd0, 3'd3, 1'b0, 1'b0};
    vt[6] = '{32'h0010_0069, 3, 7'd0, 3'd0, 1'b1, 1'b1};
    vt[7] = '{32'h0010_00E1, 3, 7'd0, 3'd0, 1'b1, 1'b1};
    vt[8] = '{32'h0010_00C3, 3, 7'd0, 3'd0, 1'b0, 1'b0};
    vt[9] = '{32'h0010_00A5, 3, 7'd5, 3'd0, SOF_EN, SOF_EN};

    // Reset state
    rst = 1'b1; dev_addr = 7'd0;
    clear_counts(); reset_model();
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    check_zero("reset");
    rst = 1'b0;
    step(0, 0, 8'h00, 0);

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 6; i++) pk[i] = 8'h00;
      for (int i = 0; i < 4; i++) pk[i] = vt[v].bytes[8*i +: 8];
      dev_addr = vt[v].dev;
      send_pkt(pk, vt[v].n);
      verify($sformatf("vec%0d", v), 0, vt[v].tok0, vt[v].ecode, pk[0], pk[1], pk[2]);
      verify($sformatf("vec%0d", v), 1, vt[v].tok1, vt[v].ecode, pk[0], pk[1], pk[2]);
    end

    // rx_error mid-packet, then a second error in the same packet must stay silent
    dev_addr = 7'd0;
    step(0, 0, 8'h00, 0); clear_counts();
    step(1, 0, 8'h00, 0); step(1, 1, 8'h2D, 0);
    step(1, 0, 8'h00, 1); step(1, 1, 8'h00, 0);
    step(1, 0, 8'h00, 1); step(1, 1, 8'h10, 0);
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) verify("rx_err", k, 1'b0, 3'd4, 8'h00, 8'h00, 8'h00);

    // rx_error coinciding with a short packet: RX_ERR wins over LEN_ERR
    step(0, 0, 8'h00, 0); clear_counts();
    step(1, 0, 8'h00, 0); step(1, 1, 8'h2D, 0); step(1, 1, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) verify("prio_rx", k, 1'b0, 3'd4, 8'h00, 8'h00, 8'h00);

    // Extra byte arriving with the falling rx_active on a bad-CRC token: LEN_ERR wins
    step(0, 0, 8'h00, 0); clear_counts();
    step(1, 0, 8'h00, 0); step(1, 1, 8'h2D, 0); step(1, 1, 8'h00, 0); step(1, 1, 8'h11, 0);
    step(0, 1, 8'h55, 0);
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) verify("prio_len", k, 1'b0, 3'd3, 8'h00, 8'h00, 8'h00);

    // Reset after byte 2, released while rx_active is still high
    step(0, 0, 8'h00, 0); clear_counts();
    step(1, 0, 8'h00, 0); step(1, 1, 8'h2D, 0); step(1, 1, 8'h00, 0);
    rst = 1'b1;
    step(1, 0, 8'h00, 0);
    reset_model();
    check_zero("mid_reset");
    step(1, 0, 8'h00, 0);
    rst = 1'b0;
    step(1, 1, 8'h10, 0);
    step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
    for (int k = 0; k < 2; k++) verify("post_reset", k, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) pk[i] = 8'h00;
    pk[0] = 8'h2D; pk[1] = 8'h00; pk[2] = 8'h10;
    send_pkt(pk, 3);
    for (int k = 0; k < 2; k++) verify("after_reset", k, 1'b1, 3'd0, pk[0], pk[1], pk[2]);

    // Random packets against the reference model
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 5);
      p = tokp[$urandom_range(0, 3)];
      f = {4'($urandom), 7'($urandom_range(0, 3))};
      for (int i = 0; i < 6; i++) pk[i] = 8'($urandom);
      pk[0] = {~p, p}; pk[1] = f[7:0]; pk[2] = make_b3(f);
      n = 3;
      case (kind)
        1: pk[2] = pk[2] ^ (8'h08 << $urandom_range(0, 4));
        2: pk[0] = pk[0] ^ (8'h01 << $urandom_range(0, 7));
        3: begin
          do p = 4'($urandom); while (p == 4'h1 || p == 4'h5 || p == 4'h9 || p == 4'hD);
          pk[0] = {~p, p};
        end
        4: n = $urandom_range(0, 2);
        5: n = $urandom_range(4, 6);
        default: ;
      endcase
      dev_addr = 7'($urandom_range(0, 3));
      send_pkt(pk, n);
      for (int k = 0; k < 2; k++) begin
        model(pk, n, k == 1, dev_addr, etok, ecode);
        verify($sformatf("rand%0d", it), k, etok, ecode, pk[0], pk[1], pk[2]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
